// File: rtl/uart_bus_slave_pkg.sv
// ---------------------------------------------------------------------------
// uart_bus_slave_pkg
// Shared definitions for the memory-mapped UART: register offsets relative to
// the block base address, CON register bit positions, the FSM state encoding
// used by both the TX and RX paths, and a helper for word-address decoding.
// ---------------------------------------------------------------------------
package uart_bus_slave_pkg;

    // Register byte offsets from BASE_ADDR
    localparam logic [31:0] REG_TXD_OFF = 32'h0;
    localparam logic [31:0] REG_RXD_OFF = 32'h4;
    localparam logic [31:0] REG_CON_OFF = 32'h8;

    // CON register bit positions
    localparam int CON_TX_IE     = 0;
    localparam int CON_RX_IE     = 1;
    localparam int CON_TX_DONE   = 2;
    localparam int CON_RX_VALID  = 3;
    localparam int CON_TX_BUSY   = 4;
    localparam int CON_FRAME_ERR = 5;
    localparam int CON_OVERRUN   = 6;

    // Serial FSM states, shared by transmitter and receiver
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } uart_state_e;

    // Word address (addr[31:2]) of a register; byte lanes are not decoded.
    function automatic logic [29:0] reg_word(input logic [31:0] base,
                                             input logic [31:0] off);
        logic [31:0] a;
        a = base + off;
        return a[31:2];
    endfunction

endpackage

// File: rtl/uart_bus_slave_if.sv
// ---------------------------------------------------------------------------
// uart_bus_slave_if
// CPU peripheral bus as seen by a bus target.
//   rd    : read strobe            (master -> slave)
//   wr    : write strobe           (master -> slave)
//   addr  : 32-bit byte address    (master -> slave)
//   wdata : 32-bit write data      (master -> slave)
//   rdata : 32-bit read data, combinational from the target (slave -> master)
// ---------------------------------------------------------------------------
interface uart_bus_slave_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output rd, wr, addr, wdata, input  rdata);
    modport slave  (input  rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
// 8N1 serial receiver: two-flop synchroniser on the asynchronous input,
// start-bit glitch rejection at half a bit, mid-bit sampling, LSB first.
// Ports:
//   clk                : system clock
//   reset              : asynchronous active-low reset
//   rxd_i              : serial input, asynchronous to clk, idle high
//   rx_byte_o          : last correctly framed byte (held until next one)
//   rx_strobe_o        : 1-cycle pulse when rx_byte_o has been updated
//   frame_err_strobe_o : 1-cycle pulse when a stop bit sampled low
// ---------------------------------------------------------------------------
module uart_rx_core
    import uart_bus_slave_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_strobe_o,
    output logic       frame_err_strobe_o
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]       sync_q;
    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             strobe_q, strobe_d;
    logic             ferr_q, ferr_d;
    logic             rxd_s;

    assign rxd_s = sync_q[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // Synchroniser resets to the idle line level so no false start.
            sync_q   <= 2'b11;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            byte_q   <= '0;
            strobe_q <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], rxd_i};
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            strobe_q <= strobe_d;
            ferr_q   <= ferr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        strobe_d = 1'b0;
        ferr_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rxd_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                // Re-check at mid start bit; a high here was only a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = '0;
                    if (rxd_s) state_d = ST_IDLE;
                    else       state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (rxd_s) begin
                        byte_d   = shift_q;
                        strobe_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rx_byte_o          = byte_q;
    assign rx_strobe_o        = strobe_q;
    assign frame_err_strobe_o = ferr_q;

endmodule

// File: rtl/uart_bus_slave.sv
// ---------------------------------------------------------------------------
// uart_bus_slave
// Memory-mapped 8N1 UART on the CPU peripheral bus. Registers:
//   BASE+0 TXD : write starts a frame when idle; read returns last byte sent
//   BASE+4 RXD : received byte; read clears rx_valid and overrun
//   BASE+8 CON : {overrun, frame_err, tx_busy, rx_valid, tx_done, rx_ie, tx_ie}
//                only [1:0] writable; read clears tx_done and frame_err
// Ports:
//   clk      : system clock
//   reset    : asynchronous active-low reset
//   bus      : peripheral bus target (rd/wr/addr/wdata in, rdata out)
//   uart_rxd : serial input, asynchronous
//   uart_txd : serial output, registered, idle high
//   irqout   : registered level interrupt
// ---------------------------------------------------------------------------
module uart_bus_slave
    import uart_bus_slave_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0018
) (
    input  logic            clk,
    input  logic            reset,
    uart_bus_slave_if.slave bus,
    input  logic            uart_rxd,
    output logic            uart_txd,
    output logic            irqout
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    // Bus decode
    logic sel_txd, sel_rxd, sel_con;
    logic wr_txd, wr_con, rd_rxd, rd_con;

    assign sel_txd = (bus.addr[31:2] == reg_word(BASE_ADDR, REG_TXD_OFF));
    assign sel_rxd = (bus.addr[31:2] == reg_word(BASE_ADDR, REG_RXD_OFF));
    assign sel_con = (bus.addr[31:2] == reg_word(BASE_ADDR, REG_CON_OFF));
    assign wr_txd  = bus.wr & sel_txd;
    assign wr_con  = bus.wr & sel_con;
    assign rd_rxd  = bus.rd & sel_rxd;
    assign rd_con  = bus.rd & sel_con;

    wire unused_bus_bits = &{1'b0, bus.addr[1:0], bus.wdata[31:8]};

    // Transmitter state
    uart_state_e      tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             txd_q, txd_d;
    logic             tx_finish;
    logic             tx_busy;

    // Status / control flags
    logic tx_done_q, tx_done_d;
    logic rx_valid_q, rx_valid_d;
    logic overrun_q, overrun_d;
    logic frame_err_q, frame_err_d;
    logic tx_ie_q, tx_ie_d;
    logic rx_ie_q, rx_ie_d;
    logic irq_q, irq_d;

    // Receiver
    logic [7:0] rx_byte;
    logic       rx_strobe;
    logic       frame_err_strobe;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk               (clk),
        .reset             (reset),
        .rxd_i             (uart_rxd),
        .rx_byte_o         (rx_byte),
        .rx_strobe_o       (rx_strobe),
        .frame_err_strobe_o(frame_err_strobe)
    );

    assign tx_busy = (tx_state_q != ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q  <= ST_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_byte_q   <= '0;
            txd_q       <= 1'b1;
            tx_done_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            tx_ie_q     <= 1'b0;
            rx_ie_q     <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_byte_q   <= tx_byte_d;
            txd_q       <= txd_d;
            tx_done_q   <= tx_done_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            tx_ie_q     <= tx_ie_d;
            rx_ie_q     <= rx_ie_d;
            irq_q       <= irq_d;
        end
    end

    // TX FSM next state
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_byte_d  = tx_byte_q;
        tx_finish  = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                // Writes while busy fall outside this branch and are dropped.
                if (wr_txd) begin
                    tx_state_d = ST_START;
                    tx_cnt_d   = '0;
                    tx_shift_d = bus.wdata[7:0];
                    tx_byte_d  = bus.wdata[7:0];
                end
            end
            ST_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_state_d = ST_DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_state_d = ST_IDLE;
                    tx_cnt_d   = '0;
                    tx_finish  = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase

        // Line level is decoded from the next state so it lands in the same
        // cycle the FSM enters that state.
        case (tx_state_d)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = tx_shift_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    // Flag updates: read-clears first, then event sets so a set on the same
    // edge wins.
    always_comb begin
        tx_done_d   = tx_done_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        tx_ie_d     = tx_ie_q;
        rx_ie_d     = rx_ie_q;

        if (rd_con) begin
            tx_done_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (rd_rxd) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end
        if (tx_finish)        tx_done_d   = 1'b1;
        if (frame_err_strobe) frame_err_d = 1'b1;
        if (rx_strobe) begin
            rx_valid_d = 1'b1;
            // The old byte is only lost if the CPU is not reading it now.
            if (rx_valid_q && !rd_rxd) overrun_d = 1'b1;
        end
        if (wr_con) begin
            tx_ie_d = bus.wdata[CON_TX_IE];
            rx_ie_d = bus.wdata[CON_RX_IE];
        end

        irq_d = (tx_ie_q & tx_done_q) | (rx_ie_q & rx_valid_q);
    end

    // Read mux
    logic [31:0] con_word;
    logic [31:0] rdata_mux;

    always_comb begin
        con_word                = '0;
        con_word[CON_TX_IE]     = tx_ie_q;
        con_word[CON_RX_IE]     = rx_ie_q;
        con_word[CON_TX_DONE]   = tx_done_q;
        con_word[CON_RX_VALID]  = rx_valid_q;
        con_word[CON_TX_BUSY]   = tx_busy;
        con_word[CON_FRAME_ERR] = frame_err_q;
        con_word[CON_OVERRUN]   = overrun_q;

        rdata_mux = '0;
        if (bus.rd) begin
            if (sel_txd)      rdata_mux = {24'b0, tx_byte_q};
            else if (sel_rxd) rdata_mux = {24'b0, rx_byte};
            else if (sel_con) rdata_mux = con_word;
        end
    end

    assign bus.rdata = rdata_mux;
    assign uart_txd  = txd_q;
    assign irqout    = irq_q;

endmodule

// File: tb/tb_uart_bus_slave.sv
`timescale 1ns/1ps
module tb_uart_bus_slave;

    localparam int unsigned CPB  = 16;
    localparam logic [31:0] BASE = 32'h4000_0018;
    localparam logic [31:0] A_TXD = BASE;
    localparam logic [31:0] A_RXD = BASE + 32'h4;
    localparam logic [31:0] A_CON = BASE + 32'h8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rxd_drv = 1'b1;
    logic loop_en = 1'b0;
    logic uart_rxd;
    logic uart_txd;
    logic irqout;

    int nvec = 0;
    int nerr = 0;

    uart_bus_slave_if bif ();

    assign uart_rxd = loop_en ? uart_txd : rxd_drv;

    uart_bus_slave #(
        .CLKS_PER_BIT(CPB),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bif.slave),
        .uart_rxd(uart_rxd),
        .uart_txd(uart_txd),
        .irqout  (irqout)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bif.addr  = a;
        bif.wdata = d;
        bif.wr    = 1'b1;
        @(posedge clk);
        #1;
        bif.wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bif.addr = a;
        bif.rd   = 1'b1;
        #1;
        d = bif.rdata;
        @(posedge clk);
        #1;
        bif.rd = 1'b0;
    endtask

    // Samples uart_txd mid-bit for the 10 bits of a frame whose accepting
    // edge was the one just before the call.
    task automatic check_tx_frame(input logic [7:0] b, input bit busy_probe);
        logic [9:0]  frame;
        logic [31:0] r;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                wait_cycles(CPB / 2);
            end else if (i == 2 && busy_probe) begin
                wait_cycles(CPB - 2);
                bus_write(A_TXD, 32'h0000_003C);
                bus_read(A_CON, r);
                nvec++;
                if (r !== 32'h10) begin
                    nerr++;
                    $display("FAIL tx_busy_con: got %h expected %h", r, 32'h10);
                end
            end else begin
                wait_cycles(CPB);
            end
            nvec++;
            if (uart_txd !== frame[i]) begin
                nerr++;
                $display("FAIL tx_bit[%0d] byte %h: got %b expected %b", i, b, uart_txd, frame[i]);
            end
        end
    endtask

    task automatic send_rx_frame(input logic [7:0] b, input logic stop);
        rxd_drv = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            wait_cycles(CPB);
        end
        rxd_drv = stop;
        wait_cycles(CPB);
        rxd_drv = 1'b1;
    endtask

    // Holds a CON read open and watches for rx_valid rising; irqout must
    // follow exactly one cycle later.
    task automatic poll_rx_irq_rise();
        bit seen;
        seen     = 1'b0;
        bif.addr = A_CON;
        bif.rd   = 1'b1;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (bif.rdata[3] === 1'b1) begin
                seen = 1'b1;
                nvec++;
                if (irqout !== 1'b0) begin
                    nerr++;
                    $display("FAIL irq_same_cycle: got %b expected %b", irqout, 1'b0);
                end
                @(posedge clk);
                #1;
                nvec++;
                if (irqout !== 1'b1) begin
                    nerr++;
                    $display("FAIL irq_next_cycle: got %b expected %b", irqout, 1'b1);
                end
            end
        end
        bif.rd = 1'b0;
        if (!seen) begin
            nvec++;
            nerr++;
            $display("FAIL rx_valid_timeout: got 0 expected 1 within 400 cycles");
        end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        #2 reset = 1'b0;
        wait_cycles(2);
        nvec++;
        if (uart_txd !== 1'b1) begin nerr++; $display("FAIL reset_txd: got %b expected 1", uart_txd); end
        nvec++;
        if (irqout !== 1'b0) begin nerr++; $display("FAIL reset_irq: got %b expected 0", irqout); end
        reset = 1'b1;
        wait_cycles(2);
        bus_read(A_TXD, r);
        nvec++;
        if (r !== 32'h0) begin nerr++; $display("FAIL reset_txd_reg: got %h expected 0", r); end
        bus_read(A_RXD, r);
        nvec++;
        if (r !== 32'h0) begin nerr++; $display("FAIL reset_rxd_reg: got %h expected 0", r); end
        bus_read(A_CON, r);
        nvec++;
        if (r !== 32'h0) begin nerr++; $display("FAIL reset_con_reg: got %h expected 0", r); end
    endtask

    task automatic test_tx();
        logic [31:0] r;
        bus_write(A_TXD, 32'h0000_00A5);
        check_tx_frame(8'hA5, 1'b1);
        wait_cycles(CPB / 2);
        bus_read(A_CON, r);
        nvec++;
        if (r !== 32'h04) begin nerr++; $display("FAIL tx_done_con: got %h expected %h", r, 32'h04); end
        bus_read(A_CON, r);
        nvec++;
        if (r !== 32'h00) begin nerr++; $display("FAIL tx_done_cleared: got %h expected %h", r, 32'h00); end
        bus_read(A_TXD, r);
        nvec++;
        if (r !== 32'hA5) begin nerr++; $display("FAIL txd_readback: got %h expected %h", r, 32'hA5); end
        nvec++;
        if (uart_txd !== 1'b1) begin nerr++; $display("FAIL tx_idle: got %b expected 1", uart_txd); end
    endtask

    task automatic test_decode();
        logic [31:0] r;
        bus_read(BASE + 32'h2, r);
        nvec++;
        if (r !== 32'hA5) begin nerr++; $display("FAIL decode_byte_lane: got %h expected %h", r, 32'hA5); end
        bus_write(BASE + 32'hC, 32'hFFFF_FFFF);
        bus_read(BASE + 32'hC, r);
        nvec++;
        if (r !== 32'h0) begin nerr++; $display("FAIL decode_unmapped: got %h expected 0", r); end
        bus_read(A_CON, r);
        nvec++;
        if (r !== 32'h0) begin nerr++; $display("FAIL decode_no_side_effect: got %h expected 0", r); end
        bus_write(A_CON, 32'hFFFF_FFFF);
        bus_read(A_CON, r);
        nvec++;
        if (r !== 32'h03) begin nerr++; $display("FAIL con_write_mask: got %h expected %h", r, 32'h03); end
        bus_write(A_CON, 32'h0);
    endtask

    task automatic test_rx();
        logic [31:0] r;
        bus_write(A_CON, 32'h02);
        fork
            send_rx_frame(8'h5A, 1'b1);
            poll_rx_irq_rise();
        join
        bus_read(A_CON, r);
        nvec++;
        if (r !== 32'h0A) begin nerr++; $display("FAIL rx_con_valid: got %h expected %h", r, 32'h0A); end
        bus_read(A_RXD, r);
        nvec++;
        if (r !== 32'h5A) begin nerr++; $display("FAIL rx_byte: got %h expected %h", r, 32'h5A); end
        wait_cycles(1);
        nvec++;
        if (irqout !== 1'b0) begin nerr++; $display("FAIL rx_irq_fall: got %b expected 0", irqout); end
        bus_read(A_CON, r);
        nvec++;
        if (r !== 32'h02) begin nerr++; $display("FAIL rx_valid_cleared: got %h expected %h", r, 32'h02); end
        bus_write(A_CON, 32'h0);
    endtask

    task automatic test_rx_errors();
        logic [31:0] r;
        send_rx_frame(8'h77, 1'b0);
        wait_cycles(20);
        bus_read(A_CON, r);
        nvec++;
        if (r !== 32'h20) begin nerr++; $display("FAIL frame_err_con: got %h expected %h", r, 32'h20); end
        bus_read(A_CON, r);
        nvec++;
        if (r !== 32'h00) begin nerr++; $display("FAIL frame_err_cleared: got %h expected 0", r); end

        send_rx_frame(8'h11, 1'b1);
        send_rx_frame(8'h22, 1'b1);
        wait_cycles(4);
        bus_read(A_CON, r);
        nvec++;
        if (r !== 32'h48) begin nerr++; $display("FAIL overrun_con: got %h expected %h", r, 32'h48); end
        bus_read(A_RXD, r);
        nvec++;
        if (r !== 32'h22) begin nerr++; $display("FAIL overrun_byte: got %h expected %h", r, 32'h22); end
        bus_read(A_CON, r);
        nvec++;
        if (r !== 32'h00) begin nerr++; $display("FAIL overrun_cleared: got %h expected 0", r); end

        rxd_drv = 1'b0;
        wait_cycles(4);
        rxd_drv = 1'b1;
        wait_cycles(12 * CPB);
        bus_read(A_CON, r);
        nvec++;
        if (r !== 32'h00) begin nerr++; $display("FAIL glitch_con: got %h expected 0", r); end
        bus_read(A_RXD, r);
        nvec++;
        if (r !== 32'h22) begin nerr++; $display("FAIL glitch_byte: got %h expected %h", r, 32'h22); end
    endtask

    task automatic test_loopback();
        logic [31:0] r;
        loop_en = 1'b1;
        bus_write(A_TXD, 32'h0000_00C3);
        wait_cycles(170);
        bus_read(A_CON, r);
        nvec++;
        if (r !== 32'h0C) begin nerr++; $display("FAIL loop_con: got %h expected %h", r, 32'h0C); end
        bus_read(A_RXD, r);
        nvec++;
        if (r !== 32'hC3) begin nerr++; $display("FAIL loop_byte: got %h expected %h", r, 32'hC3); end
        loop_en = 1'b0;
    endtask

    task automatic test_reset_midframe();
        logic [31:0] r;
        bus_write(A_CON, 32'h03);
        bus_write(A_TXD, 32'h0000_0096);
        wait_cycles(4 * CPB + CPB / 2);
        nvec++;
        if (uart_txd !== 1'b0) begin nerr++; $display("FAIL midframe_bit4: got %b expected 0", uart_txd); end
        bif.addr = A_CON;
        bif.rd   = 1'b1;
        #1;
        nvec++;
        if (bif.rdata !== 32'h13) begin nerr++; $display("FAIL midframe_con: got %h expected %h", bif.rdata, 32'h13); end
        reset = 1'b0;
        #1;
        nvec++;
        if (uart_txd !== 1'b1) begin nerr++; $display("FAIL async_reset_txd: got %b expected 1", uart_txd); end
        nvec++;
        if (bif.rdata !== 32'h0) begin nerr++; $display("FAIL async_reset_con: got %h expected 0", bif.rdata); end
        bif.rd = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        wait_cycles(2);
        bus_write(A_TXD, 32'h0000_005C);
        check_tx_frame(8'h5C, 1'b0);
        wait_cycles(CPB / 2);
        bus_read(A_CON, r);
        nvec++;
        if (r !== 32'h04) begin nerr++; $display("FAIL post_reset_con: got %h expected %h", r, 32'h04); end
    endtask

    initial begin
        bif.rd    = 1'b0;
        bif.wr    = 1'b0;
        bif.addr  = '0;
        bif.wdata = '0;
        test_reset();
        test_tx();
        test_decode();
        test_rx();
        test_rx_errors();
        test_loopback();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
